// File: rtl/regsched_pkg.sv
// Shared constants and types for the register-file write scheduler.
//  NREQ   : number of writeback requesters (0 = ALU, 1 = LOAD, 2 = MULDIV)
//  REG_AW : register address width (matches regfile rs/rt/rd)
//  NREGS  : architectural registers; r0 is hard zero
package regsched_pkg;

   localparam int unsigned NREQ   = 3;
   localparam int unsigned REG_AW = 6;
   localparam int unsigned NREGS  = 32;
   localparam int unsigned REG_IW = $clog2(NREGS);
   localparam int unsigned PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {REQ_ALU, REQ_LOAD, REQ_MULDIV} req_id_e;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [31:0]       data;
   } wb_req_t;

   // Addresses at or above NREGS name no architectural register.
   function automatic logic reg_in_range(input logic [REG_AW-1:0] addr);
      return 32'(addr) < NREGS;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at an internal pointer and wraps; the first valid
// requester wins, and the pointer moves to the slot after the winner.
//  clk_i, reset_i : clock, synchronous active-high reset (no grant while reset is high)
//  valid_i        : request vector
//  grant_o        : one-hot grant, subset of valid_i
//  grant_idx_o    : index of the granted requester
//  grant_any_o    : some requester was granted this cycle
module rr_arbiter #(
   parameter int unsigned N    = 3,
   parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic [N-1:0]    valid_i,
   output logic [N-1:0]    grant_o,
   output logic [IdxW-1:0] grant_idx_o,
   output logic            grant_any_o
);

   logic [IdxW-1:0] ptr_q, ptr_d;
   int unsigned     idx;
   logic            found;

   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      idx         = 0;
      if (!reset_i) begin
         for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!found && valid_i[idx[IdxW-1:0]]) begin
               grant_o[idx[IdxW-1:0]] = 1'b1;
               grant_idx_o            = idx[IdxW-1:0];
               found                  = 1'b1;
            end
         end
      end
      grant_any_o = found;
      ptr_d       = ptr_q;
      if (found) begin
         ptr_d = (32'(grant_idx_o) == N - 1) ? '0 : grant_idx_o + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/regwrite_sched.sv
// Schedules the single register-file write port among NREQ writeback requesters and keeps a
// per-register busy scoreboard for RAW stall detection in decode.
//  clk_i, reset_i           : clock, synchronous active-high reset
//  req_valid_i/rd_i/data_i  : per-requester write request (held stable until ready)
//  req_ready_o              : one-hot grant; handshake is valid & ready
//  claim_valid_i/claim_rd_i : issue reserves a destination register
//  chk_rs_i/chk_rt_i        : decode source operands; rs_busy_o/rt_busy_o report pending writes
//  reg_write_o/rd_o/reg_in_o: registered regfile write port, one cycle after the grant
module regwrite_sched
   import regsched_pkg::*;
(
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [NREQ-1:0]          req_valid_i,
   input  logic [NREQ*REG_AW-1:0]   req_rd_i,
   input  logic [NREQ*32-1:0]       req_data_i,
   output logic [NREQ-1:0]          req_ready_o,
   input  logic                     claim_valid_i,
   input  logic [REG_AW-1:0]        claim_rd_i,
   input  logic [REG_AW-1:0]        chk_rs_i,
   input  logic [REG_AW-1:0]        chk_rt_i,
   output logic                     rs_busy_o,
   output logic                     rt_busy_o,
   output logic                     reg_write_o,
   output logic [REG_AW-1:0]        rd_o,
   output logic [31:0]              reg_in_o
);

   wb_req_t            req [NREQ];
   wb_req_t            sel;
   logic [PTR_W-1:0]   gnt_idx;
   logic               gnt_any;

   logic               reg_write_q;
   logic [REG_AW-1:0]  rd_q;
   logic [31:0]        data_q;
   logic [NREGS-1:0]   busy_q, busy_d;

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign req[i].rd   = req_rd_i[i*REG_AW +: REG_AW];
      assign req[i].data = req_data_i[i*32 +: 32];
   end

   rr_arbiter #(
      .N    (NREQ),
      .IdxW (PTR_W)
   ) u_arb (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .valid_i     (req_valid_i),
      .grant_o     (req_ready_o),
      .grant_idx_o (gnt_idx),
      .grant_any_o (gnt_any)
   );

   assign sel = req[gnt_idx];

   // A write clears busy at the end of its cycle; a claim in the same cycle re-sets it.
   always_comb begin
      busy_d = busy_q;
      if (reg_write_q && reg_in_range(rd_q)) begin
         busy_d[rd_q[REG_IW-1:0]] = 1'b0;
      end
      if (claim_valid_i && (claim_rd_i != '0) && reg_in_range(claim_rd_i)) begin
         busy_d[claim_rd_i[REG_IW-1:0]] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         reg_write_q <= 1'b0;
         rd_q        <= '0;
         data_q      <= '0;
         busy_q      <= '0;
      end else begin
         // Writes to r0 complete the handshake but never reach the regfile.
         reg_write_q <= gnt_any && (sel.rd != '0);
         if (gnt_any) begin
            rd_q   <= sel.rd;
            data_q <= sel.data;
         end
         busy_q <= busy_d;
      end
   end

   // Reset discards an in-flight write in the very cycle it is asserted.
   assign reg_write_o = reg_write_q & ~reset_i;
   assign rd_o        = reset_i ? '0 : rd_q;
   assign reg_in_o    = reset_i ? '0 : data_q;

   assign rs_busy_o = !reset_i && reg_in_range(chk_rs_i) && busy_q[chk_rs_i[REG_IW-1:0]];
   assign rt_busy_o = !reset_i && reg_in_range(chk_rt_i) && busy_q[chk_rt_i[REG_IW-1:0]];

   for (genvar i = 0; i < NREQ; i++) begin : g_hold_chk
      a_valid_held : assert property (@(posedge clk_i) disable iff (reset_i)
         (req_valid_i[i] && !req_ready_o[i]) |=> req_valid_i[i])
         else $error("requester %0d dropped valid before grant", i);
   end

endmodule
